// File: rtl/sequencer_transport.sv
// Transport controller for the step-sequencer channel players. It owns the tempo divider,
// the play/pause/stop FSM, the count-in, and the shared step position broadcast to players.
module sequencer_transport #(
    parameter int DIV_W       = 14,
    parameter int DEFAULT_DIV = 11025,
    parameter int STEP_W      = 6,
    parameter int MAX_STEPS   = 40,
    parameter int COUNT_IN    = 4
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              play_req,
    input  logic              pause_req,
    input  logic              stop_req,
    input  logic [DIV_W-1:0]  tempo_div,
    input  logic              tempo_load,
    input  logic [STEP_W-1:0] loop_len,
    output logic [1:0]        state,
    output logic              running,
    output logic              step_pulse,
    output logic [STEP_W-1:0] step_idx,
    output logic              bar_pulse,
    output logic              count_in_pulse
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_COUNT = 2'b01,
        ST_PLAY  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0]  DEF_DIV   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [STEP_W-1:0] MAX_LEN   = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [3:0]        LAST_BEAT = 4'(COUNT_IN - 1);

    state_t            cur;
    logic [DIV_W-1:0]  div_reg;
    logic [DIV_W-1:0]  tick_cnt;
    logic [STEP_W-1:0] pos;
    logic [STEP_W-1:0] len_reg;
    logic [3:0]        beat_cnt;

    logic              tick;
    logic              go_stop;
    logic              at_last_step;
    logic [STEP_W-1:0] len_next;
    logic [DIV_W-1:0]  div_next;

    assign state = cur;

    // The divider only advances while counting in or playing; STOP/PAUSE hold it.
    assign tick         = ((cur == ST_COUNT) || (cur == ST_PLAY)) && (tick_cnt == '0);
    assign go_stop      = stop_req && (cur != ST_STOP);
    assign at_last_step = (pos >= (len_reg - STEP_ONE));

    always_comb begin
        len_next = loop_len;
        if ((loop_len == '0) || (loop_len > MAX_LEN)) begin
            len_next = MAX_LEN;
        end
    end

    // A zero divider would give a 1-clock step, which players cannot pulse against.
    always_comb begin
        div_next = tempo_div;
        if (tempo_div == '0) begin
            div_next = DIV_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            cur            <= ST_STOP;
            div_reg        <= DEF_DIV;
            tick_cnt       <= DEF_DIV;
            pos            <= '0;
            step_idx       <= '0;
            len_reg        <= MAX_LEN;
            beat_cnt       <= '0;
            running        <= 1'b0;
            step_pulse     <= 1'b0;
            bar_pulse      <= 1'b0;
            count_in_pulse <= 1'b0;
        end else begin
            step_pulse     <= 1'b0;
            bar_pulse      <= 1'b0;
            count_in_pulse <= 1'b0;

            if (tempo_load) begin
                div_reg <= div_next;
            end

            if (go_stop) begin
                // Stop wins over every other request and swallows a coincident tick.
                cur      <= ST_STOP;
                running  <= 1'b0;
                pos      <= '0;
                step_idx <= '0;
                tick_cnt <= div_reg;
                beat_cnt <= '0;
            end else begin
                case (cur)
                    ST_STOP: begin
                        if (play_req) begin
                            cur      <= ST_COUNT;
                            running  <= 1'b0;
                            tick_cnt <= div_reg;
                            beat_cnt <= '0;
                            pos      <= '0;
                            len_reg  <= len_next;
                        end
                    end

                    ST_COUNT: begin
                        if (tick) begin
                            count_in_pulse <= 1'b1;
                            tick_cnt       <= div_reg;
                            beat_cnt       <= beat_cnt + 4'd1;
                            if (beat_cnt == LAST_BEAT) begin
                                cur     <= ST_PLAY;
                                running <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt - DIV_ONE;
                        end
                    end

                    ST_PLAY: begin
                        if (pause_req) begin
                            // tick_cnt is held, so a tick lost here fires right after resume.
                            cur     <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            step_pulse <= 1'b1;
                            bar_pulse  <= (pos == '0);
                            step_idx   <= pos;
                            tick_cnt   <= div_reg;
                            if (at_last_step) begin
                                pos     <= '0;
                                len_reg <= len_next;
                            end else begin
                                pos <= pos + STEP_ONE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt - DIV_ONE;
                        end
                    end

                    ST_PAUSE: begin
                        if (play_req) begin
                            cur     <= ST_PLAY;
                            running <= 1'b1;
                        end
                    end

                    default: begin
                        cur     <= ST_STOP;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequencer_transport.sv
// Directed bench for sequencer_transport: per-cycle comparison of the packed output
// vector {state, running, step_pulse, bar_pulse, count_in_pulse, step_idx}.
module tb_sequencer_transport;

    logic       clock;
    logic       clear_n;
    logic       play_req;
    logic       pause_req;
    logic       stop_req;
    logic [13:0] tempo_div;
    logic       tempo_load;
    logic [5:0] loop_len;
    logic [1:0] state;
    logic       running;
    logic       step_pulse;
    logic [5:0] step_idx;
    logic       bar_pulse;
    logic       count_in_pulse;

    logic [11:0] obs;
    int total;
    int bad;

    assign obs = {state, running, step_pulse, bar_pulse, count_in_pulse, step_idx};

    sequencer_transport dut (
        .clock          (clock),
        .clear_n        (clear_n),
        .play_req       (play_req),
        .pause_req      (pause_req),
        .stop_req       (stop_req),
        .tempo_div      (tempo_div),
        .tempo_load     (tempo_load),
        .loop_len       (loop_len),
        .state          (state),
        .running        (running),
        .step_pulse     (step_pulse),
        .step_idx       (step_idx),
        .bar_pulse      (bar_pulse),
        .count_in_pulse (count_in_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench just after the edge that sampled play_req (k = 0).
    task automatic start_play(input logic [13:0] div, input logic [5:0] len);
        stop_req = 1'b1;
        step();
        stop_req   = 1'b0;
        tempo_div  = div;
        tempo_load = 1'b1;
        loop_len   = len;
        step();
        tempo_load = 1'b0;
        play_req   = 1'b1;
        step();
        play_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp_v;
        clear_n = 1'b0;
        play_req = 1'b1;
        repeat (3) step();
        exp_v = 12'h000;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, exp_v);
        end
        clear_n  = 1'b1;
        play_req = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_idle k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_count_in();
        logic [11:0] exp_v;
        logic [1:0] st;
        logic sp, cip;
        int idx;
        start_play(14'd3, 6'd5);
        exp_v = {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL count_entry got=%h want=%h", obs, exp_v);
        end
        for (int k = 1; k <= 60; k++) begin
            step();
            cip = (k % 4 == 0) && (k <= 16);
            sp  = (k >= 20) && ((k - 20) % 4 == 0);
            idx = (k < 20) ? 0 : ((k - 20) / 4) % 5;
            st  = (k < 16) ? 2'b01 : 2'b10;
            exp_v = {st, (st == 2'b10), sp, sp && (idx == 0), cip, 6'(idx)};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL count_in_steps k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic [11:0] exp_v;
        logic sp;
        int idx;
        start_play(14'd3, 6'd5);
        repeat (28) step();
        exp_v = {2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 6'd2};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL pause_pre_step2 got=%h want=%h", obs, exp_v);
        end
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        exp_v = {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2};
        for (int j = 0; j <= 20; j++) begin
            if (j > 0) step();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL paused_hold j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        exp_v = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL resume_entry got=%h want=%h", obs, exp_v);
        end
        for (int j = 1; j <= 8; j++) begin
            step();
            sp  = (j == 4) || (j == 8);
            idx = (j < 4) ? 2 : ((j < 8) ? 3 : 4);
            exp_v = {2'b10, 1'b1, sp, 1'b0, 1'b0, 6'(idx)};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL resume_steps j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end

        // Pause that lands on a tick: the held step fires one clock after resume.
        start_play(14'd3, 6'd5);
        repeat (23) step();
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        exp_v = {2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL pause_on_tick got=%h want=%h", obs, exp_v);
        end
        play_req = 1'b1;
        step();
        play_req = 1'b0;
        step();
        exp_v = {2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL held_tick_resume got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_requests();
        logic [11:0] exp_v;
        start_play(14'd3, 6'd5);
        repeat (30) step();
        stop_req  = 1'b1;
        pause_req = 1'b1;
        play_req  = 1'b1;
        step();
        stop_req  = 1'b0;
        pause_req = 1'b0;
        play_req  = 1'b0;
        exp_v = 12'h000;
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) step();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL all_requests j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end

        start_play(14'd3, 6'd5);
        repeat (24) step();
        exp_v = {2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL pre_stop_step1 got=%h want=%h", obs, exp_v);
        end
        repeat (3) step();
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        exp_v = 12'h000;
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) step();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL stop_on_tick j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_loop_len();
        logic [11:0] exp_v;
        logic [1:0] st;
        logic sp, cip;
        logic [5:0] lens [3];
        int n, idx;
        lens[0] = 6'd0;
        lens[1] = 6'd63;
        lens[2] = 6'd40;
        for (int m = 0; m < 3; m++) begin
            start_play(14'd1, lens[m]);
            for (int k = 1; k <= 104; k++) begin
                step();
                cip = (k % 2 == 0) && (k <= 8);
                sp  = (k >= 10) && (k % 2 == 0);
                n   = (k < 10) ? 0 : (k - 10) / 2;
                if (m == 2 && n >= 40) idx = (n - 40) % 3;
                else idx = n % 40;
                st  = (k < 8) ? 2'b01 : 2'b10;
                exp_v = {st, (st == 2'b10), sp, sp && (idx == 0), cip, 6'(idx)};
                total++;
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL loop_len m=%0d k=%0d got=%h want=%h", m, k, obs, exp_v);
                end
                if (m == 2 && k == 30) loop_len = 6'd3;
            end
        end
    endtask

    task automatic test_tempo();
        logic [11:0] exp_v;
        logic [1:0] st;
        logic sp, cip;
        int idx;
        start_play(14'd0, 6'd5);
        for (int k = 1; k <= 30; k++) begin
            step();
            cip = (k % 2 == 0) && (k <= 8);
            sp  = (k >= 10) && (k % 2 == 0);
            idx = (k < 10) ? 0 : ((k - 10) / 2) % 5;
            st  = (k < 8) ? 2'b01 : 2'b10;
            exp_v = {st, (st == 2'b10), sp, sp && (idx == 0), cip, 6'(idx)};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL tempo_zero k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end

        start_play(14'd3, 6'd5);
        for (int k = 1; k <= 41; k++) begin
            step();
            cip = (k % 4 == 0) && (k <= 16);
            sp  = (k == 20) || (k == 24) || (k == 32) || (k == 40);
            if (k < 24) idx = 0;
            else if (k < 32) idx = 1;
            else if (k < 40) idx = 2;
            else idx = 3;
            st  = (k < 16) ? 2'b01 : 2'b10;
            exp_v = {st, (st == 2'b10), sp, sp && (idx == 0), cip, 6'(idx)};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL tempo_midload k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (k == 21) begin
                tempo_div  = 14'd7;
                tempo_load = 1'b1;
            end else begin
                tempo_load = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp_v;
        start_play(14'd3, 6'd5);
        repeat (23) step();
        clear_n = 1'b0;
        step();
        exp_v = 12'h000;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_on_tick got=%h want=%h", obs, exp_v);
        end
        clear_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_mid_idle j=%0d got=%h want=%h", j, obs, exp_v);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        clear_n    = 1'b0;
        play_req   = 1'b0;
        pause_req  = 1'b0;
        stop_req   = 1'b0;
        tempo_div  = 14'd0;
        tempo_load = 1'b0;
        loop_len   = 6'd0;

        test_reset();
        test_count_in();
        test_pause_resume();
        test_requests();
        test_loop_len();
        test_tempo();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
